// File: rtl/mem_stage.sv
// Memory-access stage: performs loads/stores on a req/ready bus, stalls upstream while
// an access is outstanding, aborts after TIMEOUT wait cycles and registers the writeback.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_write_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    output logic [31:0] bp_mem,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic             r_we;
    logic [31:0]      r_wdata;
    logic [4:0]       r_rd;
    logic             r_reg_write;
    logic [31:0]      r_wb_data;
    logic [4:0]       r_wb_rd;
    logic             r_wb_reg_write;
    logic             r_misalign_err;
    logic             r_bus_err;

    logic w_access;
    logic w_aligned;
    logic w_timeout;

    assign w_access  = ex_mem_read | ex_mem_write;
    assign w_aligned = (ex_alu_result[1:0] == 2'b00);
    assign w_timeout = (r_cnt == LP_TIMEOUT);
    assign bp_mem    = ex_alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_access && w_aligned && !dmem_ready) w_next = S_WAIT;
            S_WAIT: if (dmem_ready || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus outputs are forced idle while reset is held so a frozen upstream access is not re-issued.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = ex_mem_write;
        dmem_addr  = ex_alu_result;
        dmem_wdata = ex_write_data;
        stall      = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    dmem_req = w_access && w_aligned;
                    stall    = w_access && w_aligned && !dmem_ready;
                end
                S_WAIT: begin
                    dmem_req   = dmem_ready || !w_timeout;
                    dmem_we    = r_we;
                    dmem_addr  = r_addr;
                    dmem_wdata = r_wdata;
                    stall      = !dmem_ready && !w_timeout;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_addr         <= '0;
            r_we           <= 1'b0;
            r_wdata        <= '0;
            r_rd           <= '0;
            r_reg_write    <= 1'b0;
            r_wb_data      <= '0;
            r_wb_rd        <= '0;
            r_wb_reg_write <= 1'b0;
            r_misalign_err <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_misalign_err <= 1'b0;
            r_bus_err      <= 1'b0;
            if (r_state == S_IDLE) begin
                if (!w_access) begin
                    r_wb_data      <= ex_alu_result;
                    r_wb_rd        <= ex_rd;
                    r_wb_reg_write <= ex_reg_write;
                end else if (!w_aligned) begin
                    r_misalign_err <= 1'b1;
                    r_wb_data      <= '0;
                    r_wb_rd        <= ex_rd;
                    r_wb_reg_write <= 1'b0;
                end else if (dmem_ready) begin
                    r_wb_data      <= ex_mem_write ? ex_alu_result : dmem_rdata;
                    r_wb_rd        <= ex_rd;
                    r_wb_reg_write <= ex_reg_write;
                end else begin
                    r_addr         <= ex_alu_result;
                    r_we           <= ex_mem_write;
                    r_wdata        <= ex_write_data;
                    r_rd           <= ex_rd;
                    r_reg_write    <= ex_reg_write;
                    r_cnt          <= CNT_W'(1);
                    r_wb_reg_write <= 1'b0;
                end
            end else begin
                if (dmem_ready) begin
                    r_wb_data      <= r_we ? r_addr : dmem_rdata;
                    r_wb_rd        <= r_rd;
                    r_wb_reg_write <= r_reg_write;
                    r_cnt          <= '0;
                end else if (w_timeout) begin
                    r_bus_err      <= 1'b1;
                    r_wb_data      <= '0;
                    r_wb_reg_write <= 1'b0;
                    r_cnt          <= '0;
                end else begin
                    r_cnt          <= r_cnt + CNT_W'(1);
                    r_wb_reg_write <= 1'b0;
                end
            end
        end
    end

    assign wb_data      = r_wb_data;
    assign wb_rd        = r_wb_rd;
    assign wb_reg_write = r_wb_reg_write;
    assign misalign_err = r_misalign_err;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level reference model compared every cycle, directed
// scenarios pinned with literal values, then randomized upstream/bus traffic.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_alu_result, ex_write_data, dmem_rdata;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, dmem_ready;
    logic [4:0]  ex_rd;
    logic [31:0] bp_mem, dmem_addr, dmem_wdata, wb_data;
    logic        stall, dmem_req, dmem_we, wb_reg_write, misalign_err, bus_err;
    logic [4:0]  wb_rd;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .bp_mem(bp_mem), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding transaction plus the number of cycles it has waited.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rw;
    } txn_t;

    bit          m_busy;
    int          m_waited;
    txn_t        m_txn;
    logic [31:0] m_wb_data;
    logic [4:0]  m_wb_rd;
    logic        m_wb_rw, m_mis, m_berr;
    logic        e_req, e_stall, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        s_stall, s_req;
    logic [31:0] s_addr, s_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_txn = '0;
        m_wb_data = '0; m_wb_rd = '0; m_wb_rw = 0; m_mis = 0; m_berr = 0;
    endtask

    // Works out this cycle's bus/stall behaviour and what writeback the next edge must produce.
    task automatic model_eval();
        bit acc, al, expired;
        m_mis = 0; m_berr = 0;
        acc = ex_mem_read || ex_mem_write;
        al  = (ex_alu_result % 4) == 0;
        if (!m_busy) begin
            e_req = acc && al; e_addr = ex_alu_result; e_we = ex_mem_write; e_wdata = ex_write_data;
            e_stall = e_req && !dmem_ready;
            if (!acc) begin
                m_wb_data = ex_alu_result; m_wb_rd = ex_rd; m_wb_rw = ex_reg_write;
            end else if (!al) begin
                m_wb_data = 0; m_wb_rd = ex_rd; m_wb_rw = 0; m_mis = 1;
            end else if (dmem_ready) begin
                m_wb_data = ex_mem_write ? ex_alu_result : dmem_rdata;
                m_wb_rd = ex_rd; m_wb_rw = ex_reg_write;
            end else begin
                m_txn = '{addr: ex_alu_result, we: ex_mem_write, wdata: ex_write_data,
                          rd: ex_rd, rw: ex_reg_write};
                m_busy = 1; m_waited = 1; m_wb_rw = 0;
            end
        end else begin
            expired = (m_waited == TO) && !dmem_ready;
            e_req = !expired; e_addr = m_txn.addr; e_we = m_txn.we; e_wdata = m_txn.wdata;
            e_stall = !dmem_ready && (m_waited != TO);
            if (dmem_ready) begin
                m_wb_data = m_txn.we ? m_txn.addr : dmem_rdata;
                m_wb_rd = m_txn.rd; m_wb_rw = m_txn.rw; m_busy = 0;
            end else if (expired) begin
                m_wb_data = 0; m_wb_rw = 0; m_berr = 1; m_busy = 0;
            end else begin
                m_waited++; m_wb_rw = 0;
            end
        end
    endtask

    task automatic check_regs();
        chk("wb_data", wb_data, m_wb_data);
        chk("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(m_wb_rw));
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
        chk("bus_err", 32'(bus_err), 32'(m_berr));
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic mr,
                         input logic mw, input logic rw, input logic [4:0] rd,
                         input logic rdy, input logic [31:0] rdat);
        ex_alu_result = alu; ex_write_data = wd; ex_mem_read = mr; ex_mem_write = mw;
        ex_reg_write = rw; ex_rd = rd; dmem_ready = rdy; dmem_rdata = rdat;
    endtask

    // One clock: inputs already driven just after an edge; check comb, then registered outputs.
    task automatic step();
        #1;
        model_eval();
        s_stall = stall; s_req = dmem_req; s_addr = dmem_addr; s_wdata = dmem_wdata;
        chk("stall", 32'(stall), 32'(e_stall));
        chk("dmem_req", 32'(dmem_req), 32'(e_req));
        chk("bp_mem", bp_mem, ex_alu_result);
        if (e_req) begin
            chk("dmem_addr", dmem_addr, e_addr);
            chk("dmem_we", 32'(dmem_we), 32'(e_we));
            chk("dmem_wdata", dmem_wdata, e_wdata);
        end
        @(posedge clk); #1;
        check_regs();
    endtask

    logic [31:0] r_alu, r_wd;
    logic        r_mr, r_mw, r_rw;
    logic [4:0]  r_rd;

    initial begin
        rst = 1'b1;
        drive(32'h0, 32'h0, 0, 0, 0, 5'd0, 0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("reset_dmem_req", 32'(dmem_req), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        rst = 1'b0;

        // ALU op
        drive(32'h1234, 32'h0, 0, 0, 1, 5'd5, 0, 32'h0); step();
        chk("alu_stall", 32'(s_stall), 32'h0);
        chk("alu_req", 32'(s_req), 32'h0);
        chk("alu_wb_data", wb_data, 32'h1234);
        chk("alu_wb_rd", 32'(wb_rd), 32'd5);
        chk("alu_wb_rw", 32'(wb_reg_write), 32'h1);

        // zero-wait load
        drive(32'h100, 32'h0, 1, 0, 1, 5'd7, 1, 32'hDEADBEEF); step();
        chk("zw_stall", 32'(s_stall), 32'h0);
        chk("zw_addr", s_addr, 32'h100);
        chk("zw_wb_data", wb_data, 32'hDEADBEEF);
        chk("zw_wb_rw", 32'(wb_reg_write), 32'h1);

        // 3-wait store
        for (int i = 0; i < 4; i++) begin
            drive(32'h200, 32'hCAFEF00D, 0, 1, 0, 5'd3, (i == 3), 32'h5555_AAAA); step();
            chk("st_addr", s_addr, 32'h200);
            chk("st_wdata", s_wdata, 32'hCAFEF00D);
            chk("st_stall", 32'(s_stall), (i < 3) ? 32'h1 : 32'h0);
            if (i < 3) chk("st_bubble", 32'(wb_reg_write), 32'h0);
        end
        chk("st_wb_data", wb_data, 32'h200);

        // misaligned load
        drive(32'h102, 32'h0, 1, 0, 1, 5'd9, 1, 32'h0); step();
        chk("mis_req", 32'(s_req), 32'h0);
        chk("mis_stall", 32'(s_stall), 32'h0);
        chk("mis_err", 32'(misalign_err), 32'h1);
        chk("mis_wb_rw", 32'(wb_reg_write), 32'h0);
        drive(32'h44, 32'h0, 0, 0, 1, 5'd2, 0, 32'h0); step();
        chk("mis_pulse_end", 32'(misalign_err), 32'h0);

        // timeout
        for (int i = 0; i < 5; i++) begin
            drive(32'h300, 32'h0, 1, 0, 1, 5'd4, 0, 32'h0); step();
            chk("to_stall", 32'(s_stall), (i < 4) ? 32'h1 : 32'h0);
            chk("to_req", 32'(s_req), (i < 4) ? 32'h1 : 32'h0);
            chk("to_bus_err", 32'(bus_err), (i == 4) ? 32'h1 : 32'h0);
        end
        chk("to_wb_rw", 32'(wb_reg_write), 32'h0);
        drive(32'h77, 32'h0, 0, 0, 1, 5'd6, 0, 32'h0); step();
        chk("to_after_data", wb_data, 32'h77);
        chk("to_after_err", 32'(bus_err), 32'h0);

        // reset during the second wait cycle
        drive(32'h400, 32'h1111, 0, 1, 1, 5'd8, 0, 32'h0); step();
        step();
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        check_regs();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(32'h500, 32'h0, 0, 0, 0, 5'd1, 1, 32'h9999); step();
        chk("rst_no_wb", 32'(wb_reg_write), 32'h0);
        chk("rst_no_berr", 32'(bus_err), 32'h0);

        // randomized traffic; upstream holds its transaction while stalled
        r_alu = 0; r_wd = 0; r_mr = 0; r_mw = 0; r_rw = 0; r_rd = 0;
        e_stall = 0;
        for (int n = 0; n < 600; n++) begin
            if (!e_stall) begin
                int kind;
                kind = $urandom_range(0, 4);
                r_alu = $urandom; r_wd = $urandom; r_rd = 5'($urandom);
                r_rw = 1'($urandom); r_mr = (kind == 1) || (kind == 3);
                r_mw = (kind == 2) || (kind == 3);
                if (kind != 0 && $urandom_range(0, 3) != 0) r_alu[1:0] = 2'b00;
            end
            drive(r_alu, r_wd, r_mr, r_mw, r_rw, r_rd, ($urandom_range(0, 9) < 3), $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
